// File: rtl/core_ahb_master.sv
// Single-outstanding AHB-Lite master arbitrating an instruction-fetch port and a load/store port.
// Alignment faults complete locally through MERR without touching the bus.
module core_ahb_master #(
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [1:0]  dm_size,
  input  logic        dm_unsigned,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic [31:0] dm_rdata,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_MERR} state_t;

  state_t      state, state_nxt;
  logic        lat_port, lat_we, lat_uns, flushed;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_size;
  logic [3:0]  lat_prot;

  logic        fetch_go, pick_data, pick_fetch, take, misalign, done, err_now;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    fetch_go   = if_req && !if_flush;
    pick_data  = dm_req && (!fetch_go || DATA_PRIORITY != 0);
    pick_fetch = fetch_go && !pick_data;
    take       = pick_data || pick_fetch;
    sel_addr   = pick_data ? dm_addr : if_addr;
    sel_size   = pick_data ? dm_size : 2'b10;
    misalign   = (sel_size == 2'b11)
              || (sel_size == 2'b01 && sel_addr[0])
              || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    state_nxt  = state;
    case (state)
      S_IDLE:  if (take) state_nxt = misalign ? S_MERR : S_ADDR;
      S_ADDR:  if (HREADY) state_nxt = S_DATA;
      S_DATA:  if (HREADY) state_nxt = S_IDLE;
      S_MERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // The latched copy drives the bus for the whole transfer, so requesters may change inputs freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      lat_prot  <= '0;
      flushed   <= 1'b0;
    end else if (state == S_IDLE && take) begin
      lat_port  <= pick_data;
      lat_we    <= pick_data && dm_we;
      lat_uns   <= dm_unsigned;
      lat_addr  <= sel_addr;
      lat_wdata <= pick_data ? dm_wdata : '0;
      lat_size  <= sel_size;
      lat_prot  <= pick_data ? 4'b0011 : 4'b0010;
      flushed   <= 1'b0;
    end else if ((state == S_ADDR || state == S_DATA) && !lat_port && if_flush) begin
      flushed   <= 1'b1;
    end
  end

  always_comb begin
    HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
    HADDR     = lat_addr;
    HSIZE     = {1'b0, lat_size};
    HPROT     = lat_prot;
    HWRITE    = lat_we;
    HBURST    = '0;
    HMASTLOCK = 1'b0;
    case (lat_size)
      2'b00:   HWDATA = {4{lat_wdata[7:0]}};
      2'b01:   HWDATA = {2{lat_wdata[15:0]}};
      default: HWDATA = lat_wdata;
    endcase
  end

  always_comb begin
    case (lat_addr[1:0])
      2'b00:   rd_byte = HRDATA[7:0];
      2'b01:   rd_byte = HRDATA[15:8];
      2'b10:   rd_byte = HRDATA[23:16];
      default: rd_byte = HRDATA[31:24];
    endcase
    rd_half = lat_addr[1] ? HRDATA[31:16] : HRDATA[15:0];
    case (lat_size)
      2'b00:   rd_ext = {{24{~lat_uns & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{~lat_uns & rd_half[15]}}, rd_half};
      default: rd_ext = HRDATA;
    endcase
  end

  // A flush arriving in the completion cycle itself must also swallow the fetch ack.
  always_comb begin
    done     = (state == S_DATA && HREADY) || state == S_MERR;
    err_now  = (state == S_MERR) || HRESP;
    if_ack   = done && !lat_port && !flushed && !if_flush;
    dm_ack   = done && lat_port;
    if_err   = if_ack && err_now;
    dm_err   = dm_ack && err_now;
    if_rdata = (if_ack && state == S_DATA) ? HRDATA : '0;
    dm_rdata = (dm_ack && state == S_DATA && !lat_we) ? rd_ext : '0;
  end

endmodule

// File: tb/tb_core_ahb_master.sv
// Directed bench for core_ahb_master: queue-based transaction model plus a small AHB slave.
module tb_core_ahb_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_unsigned = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [1:0]  dm_size = '0;
  logic        if_ack, if_err, dm_ack, dm_err, HMASTLOCK, HWRITE;
  logic [31:0] if_rdata, dm_rdata, HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  core_ahb_master #(.DATA_PRIORITY(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_size(dm_size),
    .dm_unsigned(dm_unsigned), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        write;
    logic [31:0] wdata;
  } bus_t;
  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  bus_t bus_q[$];
  ack_t ack_q[$];

  function automatic logic [31:0] m_load(input logic [31:0] hr, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (hr >> (8 * int'(a[1:0]))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (hr >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = hr;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'b00) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'b01) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic m_misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // ---------------- compare process ----------------
  int          cyc_n = 0;
  logic        acc_n = 1'b0;
  int          acc_cyc = 0, ack_cyc = 0, acks_seen = 0;
  logic        dp_active = 1'b0, dp_write = 1'b0;
  logic [31:0] dp_wdata = '0;
  logic [31:0] last_if_rdata = '0, last_dm_rdata = '0, last_hwdata = '0;
  logic        last_dm_err = 1'b0, last_if_err = 1'b0;
  bus_t        cb;
  ack_t        ca;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    acc_n = 1'b0;
    if (!reset_n) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active) begin
        if (dp_write) chk("hwdata_hold", HWDATA, dp_wdata);
        if (HREADY) dp_active = 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        acc_n   = 1'b1;
        acc_cyc = cyc_n;
        chk("bus_pending", bus_q.size() != 0, 1);
        if (bus_q.size() != 0) begin
          cb = bus_q.pop_front();
          chk("haddr", HADDR, cb.addr);
          chk("hsize", HSIZE, cb.size);
          chk("hprot", HPROT, cb.prot);
          chk("hwrite", HWRITE, cb.write);
          chk("hburst_lock", {HBURST, HMASTLOCK}, 0);
          dp_active = 1'b1;
          dp_write  = cb.write;
          dp_wdata  = cb.wdata;
        end
      end
      if (if_ack || dm_ack) begin
        chk("one_ack", if_ack & dm_ack, 0);
        chk("ack_pending", ack_q.size() != 0, 1);
        if (ack_q.size() != 0) begin
          ca = ack_q.pop_front();
          chk("ack_port", dm_ack, ca.port);
          chk("ack_err", dm_ack ? dm_err : if_err, ca.err);
          chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, ca.rdata);
        end
        last_if_rdata = if_rdata;
        last_dm_rdata = dm_rdata;
        last_dm_err   = dm_err;
        last_if_err   = if_err;
        last_hwdata   = HWDATA;
        ack_cyc       = cyc_n;
        acks_seen++;
      end
    end
  end

  // ---------------- AHB slave ----------------
  int          slv_waits = 0;
  logic        slv_err = 1'b0, hold_low = 1'b0, in_dp = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          dp_left = 0;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp && HREADY) in_dp = 1'b0;
      if (acc_n) begin
        in_dp   = 1'b1;
        dp_left = slv_waits + (slv_err ? 1 : 0);
      end
    end
    HRDATA = slv_rdata;
    if (in_dp && dp_left > 0) begin
      HREADY = 1'b0;
      HRESP  = slv_err && dp_left == 1;
      dp_left--;
    end else if (in_dp) begin
      HREADY = 1'b1;
      HRESP  = slv_err;
    end else begin
      HREADY = !hold_low;
      HRESP  = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_acks(input int target, input int budget);
    int   n = 0;
    logic sd, si;
    while (acks_seen < target && n < budget) begin
      @(negedge clk);
      sd = dm_ack;
      si = if_ack;
      @(posedge clk);
      #1;
      if (sd) dm_req = 1'b0;
      if (si) if_req = 1'b0;
      n++;
    end
    chk("ack_timeout", acks_seen >= target, 1);
  endtask

  task automatic data_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input logic [31:0] hr,
                         input int waits, input logic err, output int t0);
    logic mis;
    int   base;
    mis       = m_misaligned(addr, size);
    slv_rdata = hr;
    slv_waits = waits;
    slv_err   = err;
    if (!mis) bus_q.push_back('{addr, {1'b0, size}, 4'b0011, we, m_wdata(size, wdata)});
    ack_q.push_back('{1'b1, mis | err, (mis || we) ? 32'h0 : m_load(hr, addr, size, uns)});
    t0 = cyc_n;
    base = acks_seen;
    dm_we = we; dm_addr = addr; dm_size = size; dm_unsigned = uns; dm_wdata = wdata;
    dm_req = 1'b1;
    wait_acks(base + 1, 20);
  endtask

  task automatic fetch_op(input logic [31:0] addr, input logic [31:0] hr, output int t0);
    logic mis;
    int   base;
    mis       = addr[1:0] != 2'b00;
    slv_rdata = hr;
    slv_waits = 0;
    slv_err   = 1'b0;
    if (!mis) bus_q.push_back('{addr, 3'b010, 4'b0010, 1'b0, 32'h0});
    ack_q.push_back('{1'b0, mis, mis ? 32'h0 : hr});
    t0 = cyc_n;
    base = acks_seen;
    if_addr = addr;
    if_req  = 1'b1;
    wait_acks(base + 1, 20);
  endtask

  logic [31:0] mis_addr [4] = '{32'h401, 32'h401, 32'h000, 32'h402};
  logic [1:0]  mis_size [4] = '{2'b10, 2'b01, 2'b11, 2'b10};

  initial begin
    int   t0, base;
    logic got;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_ctrl", {HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK}, 0);
    chk("rst_acks", {if_ack, if_err, dm_ack, dm_err}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Zero-wait fetch
    fetch_op(32'h100, 32'h00500093, t0);
    chk("fetch_addr_cycle", acc_cyc - t0, 1);
    chk("fetch_latency", ack_cyc - t0, 2);
    chk("fetch_rdata", last_if_rdata, 32'h00500093);

    // Simultaneous requests: data port first
    slv_rdata = 32'h00000013; slv_waits = 0; slv_err = 1'b0;
    bus_q.push_back('{32'h500, 3'b010, 4'b0011, 1'b1, 32'hCAFEF00D});
    bus_q.push_back('{32'h104, 3'b010, 4'b0010, 1'b0, 32'h0});
    ack_q.push_back('{1'b1, 1'b0, 32'h0});
    ack_q.push_back('{1'b0, 1'b0, 32'h00000013});
    base = acks_seen;
    dm_we = 1'b1; dm_addr = 32'h500; dm_size = 2'b10; dm_wdata = 32'hCAFEF00D;
    if_addr = 32'h104;
    dm_req = 1'b1; if_req = 1'b1;
    wait_acks(base + 2, 30);
    chk("prio_count", acks_seen - base, 2);
    chk("prio_last_fetch", last_if_rdata, 32'h00000013);

    // Byte / half loads with extension
    data_op(1'b0, 32'h203, 2'b00, 1'b0, 0, 32'h80FFFFFF, 0, 1'b0, t0);
    chk("lb_signed", last_dm_rdata, 32'hFFFFFF80);
    data_op(1'b0, 32'h203, 2'b00, 1'b1, 0, 32'h80FFFFFF, 0, 1'b0, t0);
    chk("lb_unsigned", last_dm_rdata, 32'h00000080);
    data_op(1'b0, 32'h0A2, 2'b01, 1'b0, 0, 32'h80017FFF, 0, 1'b0, t0);
    chk("lh_signed_hi", last_dm_rdata, 32'hFFFF8001);
    data_op(1'b0, 32'h0A0, 2'b01, 1'b0, 0, 32'h80017FFF, 1, 1'b0, t0);
    chk("lh_low", last_dm_rdata, 32'h00007FFF);
    data_op(1'b0, 32'h0A1, 2'b00, 1'b1, 0, 32'h1234ABCD, 0, 1'b0, t0);

    // Half store with three wait states
    data_op(1'b1, 32'h402, 2'b01, 1'b0, 32'h1234, 32'h0, 3, 1'b0, t0);
    chk("hst_ack_cycle", ack_cyc - acc_cyc, 4);
    chk("hst_hwdata", last_hwdata, 32'h12341234);
    chk("hst_rdata", last_dm_rdata, 0);

    // Alignment faults complete one cycle after the request
    for (int i = 0; i < 4; i++) begin
      data_op(1'b0, mis_addr[i], mis_size[i], 1'b0, 0, 32'h55AA55AA, 0, 1'b0, t0);
      chk("merr_latency", ack_cyc - t0, 1);
      chk("merr_err", last_dm_err, 1);
    end
    fetch_op(32'h102, 32'h0, t0);
    chk("fetch_merr", last_if_err, 1);

    // Two-cycle error response
    data_op(1'b0, 32'h600, 2'b10, 1'b0, 0, 32'hDEADBEEF, 0, 1'b1, t0);
    chk("err_flag", last_dm_err, 1);
    chk("err_cycle", ack_cyc - acc_cyc, 2);

    // Flush during DATA: bus completes, no ack
    slv_waits = 2; slv_err = 1'b0;
    bus_q.push_back('{32'h200, 3'b010, 4'b0010, 1'b0, 32'h0});
    base = acks_seen;
    if_addr = 32'h200; if_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      got = acc_n;
    end
    chk("flush_addr_seen", got, 1);
    @(posedge clk); #1;
    if_req = 1'b0; if_flush = 1'b1;
    @(posedge clk); #1;
    if_flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_no_ack", acks_seen, base);

    // Flush in IDLE: the fetch must not start
    if_addr = 32'h300; if_req = 1'b1; if_flush = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_htrans", HTRANS, 0);
    fetch_op(32'h108, 32'h00A00113, t0);
    chk("after_flush_fetch", last_if_rdata, 32'h00A00113);

    // Reset asserted while the address phase is stalled
    hold_low = 1'b1;
    @(posedge clk); #1;
    base = acks_seen;
    dm_we = 1'b0; dm_addr = 32'h300; dm_size = 2'b10; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stalled_addr", HTRANS, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_htrans", HTRANS, 0);
    chk("async_haddr", HADDR, 0);
    chk("async_acks", {if_ack, dm_ack}, 0);
    dm_req = 1'b0; hold_low = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_ack_after_reset", acks_seen, base);

    // First transfer right after reset release
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    fetch_op(32'h10C, 32'h00000073, t0);
    chk("post_reset_latency", ack_cyc - t0, 2);

    repeat (3) @(posedge clk);
    chk("ackq_drained", ack_q.size(), 0);
    chk("busq_drained", bus_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
